// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first, odd parity, stop, ACK check.
// Pads are open-drain: the *_oe outputs only ever pull a line low.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic [2:0] fsm_state
);

    // Handshake: a byte is taken on any posedge where tx_valid && tx_ready; tx_ready is high only in IDLE.

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [1:0]    pads;
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [FW-1:0] fcnt [2];
    logic          fall_clk;

    logic [7:0]    data_q;
    logic          parity_q;
    logic          drive_q;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    err_code_q;

    logic          inh_last, tmo_hit, ack_edge;

    // Index 0 is CLK, index 1 is DATA.
    assign pads = {ps2_data_i, ps2_clk_i};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            filt_d  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= pads;
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_CYCLES - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign fall_clk = filt_d[0] & ~filt[0];

    assign inh_last = (state_q == S_INHIBIT) && (inh_cnt == IW'(INHIBIT_CYCLES - 1));
    assign tmo_hit  = (state_q == S_REQ) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign ack_edge = (state_q == S_REQ) && fall_clk && (bit_cnt == 4'd10);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Timeout is tested before the ACK edge so it wins when both land together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (tx_valid) state_d = S_INHIBIT;
            S_INHIBIT:   if (inh_last) state_d = S_REQ;
            S_REQ: begin
                if (tmo_hit)       state_d = S_FAIL;
                else if (ack_edge) state_d = filt[1] ? S_FAIL : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: if (filt == 2'b11) state_d = S_IDLE;
            S_FAIL:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_ready    = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_WAIT_IDLE) && (filt == 2'b11);
        err         = (state_q == S_FAIL);
        ps2_clk_oe  = (state_q == S_INHIBIT);
        ps2_data_oe = inh_last || ((state_q == S_REQ) && drive_q);
        err_code    = err_code_q;
        fsm_state   = state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q     <= '0;
            parity_q   <= 1'b0;
            drive_q    <= 1'b0;
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            err_code_q <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tx_valid) begin
                        data_q     <= tx_data;
                        parity_q   <= ~^tx_data;
                        err_code_q <= 2'b00;
                        inh_cnt    <= '0;
                    end
                end
                S_INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_last) begin
                        tmo_cnt <= '0;
                        bit_cnt <= '0;
                        drive_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_hit) begin
                        err_code_q <= 2'b01;
                    end else if (fall_clk) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        // Edge n presents bit n-1; edge 11 is the ACK sample point.
                        case (bit_cnt)
                            4'd0, 4'd1, 4'd2, 4'd3,
                            4'd4, 4'd5, 4'd6, 4'd7: drive_q <= ~data_q[bit_cnt[2:0]];
                            4'd8:                   drive_q <= ~parity_q;
                            4'd9:                   drive_q <= 1'b0;
                            4'd10: if (filt[1])     err_code_q <= 2'b10;
                            default:                drive_q <= 1'b0;
                        endcase
                    end
                end
                default: begin
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on wired-AND pads.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TMO = 5000;
    localparam int FLT = 2;

    localparam int M_ACK   = 0;
    localparam int M_NACK  = 1;
    localparam int M_NOCLK = 2;
    localparam int M_ABORT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, err;
    logic [1:0] err_code;
    logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
    logic [2:0] fsm_state;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_CYCLES(FLT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done),
        .err(err),
        .err_code(err_code),
        .ps2_clk_i(ps2_clk_i),
        .ps2_data_i(ps2_data_i),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_done = 0;
    int n_err = 0;
    int err_cyc = 0;
    always @(negedge clk) begin
        if (done) n_done++;
        if (err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // driver tasks
    task automatic send_req(input logic [7:0] b);
        int g;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!busy && g < 50);
        tx_valid = 1'b0;
        if (!busy) bound_expired("accept");
    endtask

    task automatic device_session(input int mode, output logic [10:0] frame,
                                  output int inh_cnt, output int pre_cnt, output int rel_cyc);
        int g;
        int nclk;
        frame   = '0;
        inh_cnt = 0;
        pre_cnt = 0;
        g       = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && g < 1000) begin
            if (ps2_clk_oe) inh_cnt++;
            if (ps2_clk_oe && ps2_data_oe) pre_cnt++;
            @(negedge clk);
            g++;
        end
        rel_cyc = cyc;
        if (g >= 1000) begin
            bound_expired("request");
            return;
        end
        frame[0] = ps2_data_i;
        if (mode == M_NOCLK) return;
        nclk = (mode == M_ABORT) ? 4 : 10;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= nclk; i++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            frame[i] = ps2_data_i;
            repeat (20) @(negedge clk);
        end
        if (mode == M_ABORT) return;
        dev_data = (mode == M_ACK) ? 1'b0 : 1'b1;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_end(input int base, input int limit, output bit seen);
        int g;
        g = 0;
        while (n_done + n_err == base && g < limit) begin
            @(posedge clk);
            g++;
        end
        seen = (n_done + n_err != base);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  data;
        int          mode;
        logic [10:0] frame;
        int          exp_done;
        int          exp_err;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] fr;
        int inh, pre, rel, bd, be;
        bit seen;

        // frame = {stop, parity, data[7:0], start}; parity hand-computed (odd)
        vecs[0] = '{8'hED, M_ACK,   {1'b1, 1'b1, 8'hED, 1'b0}, 1, 0, 2'b00};
        vecs[1] = '{8'h01, M_ACK,   {1'b1, 1'b0, 8'h01, 1'b0}, 1, 0, 2'b00};
        vecs[2] = '{8'h00, M_ACK,   {1'b1, 1'b1, 8'h00, 1'b0}, 1, 0, 2'b00};
        vecs[3] = '{8'hA5, M_NACK,  {1'b1, 1'b1, 8'hA5, 1'b0}, 0, 1, 2'b10};
        vecs[4] = '{8'h12, M_NOCLK, 11'h000,                   0, 1, 2'b01};
        vecs[5] = '{8'h3C, M_ACK,   {1'b1, 1'b1, 8'h3C, 1'b0}, 1, 0, 2'b00};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_state", fsm_state, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            bd = n_done;
            be = n_err;
            send_req(vecs[i].data);
            device_session(vecs[i].mode, fr, inh, pre, rel);
            wait_end(bd + be, 8000, seen);
            if (!seen) bound_expired("end_of_transfer");
            check("inhibit_len", inh, INH);
            check("data_low_before_release", pre, 1);
            if (vecs[i].mode == M_NOCLK) check("timeout_latency", err_cyc - rel, TMO);
            else check("frame", fr, vecs[i].frame);
            check("err_code", err_code, vecs[i].code);
            @(negedge clk);
            check("post_tx_ready", tx_ready, 1);
            check("post_clk_oe", ps2_clk_oe, 0);
            check("post_data_oe", ps2_data_oe, 0);
            repeat (10) @(negedge clk);
            check("done_pulses", n_done - bd, vecs[i].exp_done);
            check("err_pulses", n_err - be, vecs[i].exp_err);
        end

        // tx_valid while busy is ignored; valid in the first IDLE cycle after done is taken
        bd = n_done;
        be = n_err;
        send_req(8'h81);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        check("busy_not_ready", tx_ready, 0);
        device_session(M_ACK, fr, inh, pre, rel);
        tx_valid = 1'b0;
        check("busy_frame", fr, {1'b1, 1'b1, 8'h81, 1'b0});
        wait_end(bd + be, 200, seen);
        if (!seen) bound_expired("busy_end");
        check("busy_done", n_done - bd, 1);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        check("b2b_ready", tx_ready, 1);
        @(negedge clk);
        check("b2b_accepted", busy, 1);
        tx_valid = 1'b0;
        bd = n_done;
        be = n_err;
        device_session(M_ACK, fr, inh, pre, rel);
        check("b2b_frame", fr, {1'b1, 1'b1, 8'h55, 1'b0});
        wait_end(bd + be, 200, seen);
        if (!seen) bound_expired("b2b_end");
        repeat (5) @(negedge clk);
        check("b2b_done", n_done - bd, 1);
        check("b2b_err", n_err - be, 0);

        // reset during bit 4, then a clean 0xFF transfer
        send_req(8'h96);
        device_session(M_ABORT, fr, inh, pre, rel);
        check("abort_mid_drive_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_clk_oe", ps2_clk_oe, 0);
        check("abort_data_oe", ps2_data_oe, 0);
        check("abort_state", fsm_state, 0);
        check("abort_tx_ready", tx_ready, 1);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        bd = n_done;
        be = n_err;
        send_req(8'hFF);
        device_session(M_ACK, fr, inh, pre, rel);
        check("ff_frame", fr, {1'b1, 1'b1, 8'hFF, 1'b0});
        wait_end(bd + be, 200, seen);
        if (!seen) bound_expired("ff_end");
        repeat (5) @(negedge clk);
        check("ff_done", n_done - bd, 1);
        check("ff_err", n_err - be, 0);
        check("ff_err_code", err_code, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It is the outbound counterpart to the keyboard receiver path.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the PS/2 request-to-send sequence over open-drain CLK/DATA.
- Reports ACK or error, then returns the bus to idle.
- Sits beside the PS/2 receiver at top level. `busy` lets the receiver ignore the bus during host transmission.

Parameters:
- INHIBIT_CYCLES, 12000, clk cycles CLK is held low before start (120 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, max clk cycles from CLK release to ACK sample (15 ms).
- FILTER_CYCLES, 8, consecutive equal samples needed to update a filtered line.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (sampled on posedge clk).
- tx_valid  in  1  request to send tx_data.
- tx_data  in  8  command byte.
- tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid && tx_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: byte sent and ACKed.
- err  out  1  one-cycle pulse: transfer failed.
- err_code  out  2  01 = timeout, 10 = no ACK; holds until next accept.
- ps2_clk_i  in  1  PS/2 CLK pad level.
- ps2_data_i  in  1  PS/2 DATA pad level.
- ps2_clk_oe  out  1  1 = pull CLK low; 0 = release.
- ps2_data_oe  out  1  1 = pull DATA low; 0 = release.

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE; all counters 0.
  - tx_ready=1, busy=0, done=0, err=0, err_code=00.
  - Both oe=0.
  - Synchronizer and filter registers = 1.
  - Reset mid-transfer releases both lines on the next edge.
- Input conditioning:
  - Each line passes a 2-FF synchronizer, then the filter.
  - The filtered value updates only after FILTER_CYCLES identical synchronized samples.
  - fall_clk = filtered CLK goes 1->0.
- Accept: on tx_valid && tx_ready, latch tx_data, compute parity = ~^tx_data (odd parity), clear err_code, go to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES. In the final cycle data_oe=1 (DATA low before CLK release). Then go to REQ and clear the timeout counter.
- REQ/SHIFT: clk_oe=0, data_oe=1 (start bit).
  - Count fall_clk edges n=1..11.
  - On edge n, data_oe updates the next clk cycle:
    - n=1..8: data_oe = ~tx_data[n-1] (LSB first).
    - n=9: data_oe = ~parity.
    - n=10: data_oe=0 (stop bit, released).
    - n=11: sample filtered DATA. 0 -> ACK, go to WAIT_IDLE. 1 -> err_code=10, go to FAIL.
- Timeout: the counter runs from REQ entry until edge 11. Reaching TIMEOUT_CYCLES -> both oe=0, err_code=01, go to FAIL.
- WAIT_IDLE: both oe=0. Wait until filtered CLK and DATA are both 1, then pulse done and go to IDLE. No timeout in this state.
- FAIL: both oe=0. Pulse err for one cycle, then go to IDLE.
- tx_valid is ignored while busy.
- If fall_clk and timeout occur in the same cycle, timeout wins.
- The module never drives a pad high. Top level maps oe to tri-state: 0 when oe, else Z.

Test Plan:
(Bench uses INHIBIT_CYCLES=100, FILTER_CYCLES=2, TIMEOUT_CYCLES=5000. The device model clocks at a 40-cycle period, samples DATA on rising edges, and drives ACK low on the 11th clock.)
- Send 0xED -> CLK held low exactly 100 cycles. Device samples start 0, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1. ACK -> done pulses once after lines idle; err=0, err_code=00.
- Send 0x01 -> parity sampled 0. Send 0x00 -> parity sampled 1. Both end with done.
- Device never clocks -> err pulses 5000 cycles after CLK release, err_code=01, both oe=0, tx_ready=1.
- Device leaves DATA high on the 11th clock -> err pulses, err_code=10, no done.
- Assert tx_valid with 0x55 while busy -> ignored; only the first byte is transmitted. A back-to-back valid in the first IDLE cycle after done is accepted.
- Drive rst=0 during bit 4 -> both oe=0 and state=IDLE on the next edge, tx_ready=1. A new send of 0xFF completes normally.
